ntt_loader: RTL and testbench

NTT_LOADER -- requirements
Module: ntt_loader

---
 rtl/ntt_loader.sv | 98 +++++++++
 tb/tb_ntt_loader.sv | 122 ++++++++++++
 2 files changed

// File: rtl/ntt_loader.sv
// ntt_loader: streams 2048 coefficient words into an NTT processor, then starts it and waits for done.
// Define NTT_LOADER_BITREV_EN to land the natural-order stream at bit-reversed addresses.
module ntt_loader #(
  parameter int LOG_CORE_COUNT = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        go,
  input  logic [59:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic        write_enable,
  output logic [10:0] address_in,
  output logic [59:0] data_in,
  output logic        start,
  input  logic        done,
  output logic        busy,
  output logic        ntt_done
);
  typedef enum logic [2:0] {IDLE, LOAD, GAP, START, WAIT, FIN} state_t;
  state_t      r_state;
  logic [10:0] r_cnt;
  logic [1:0]  r_hold;
  logic        r_we;
  logic [10:0] r_addr;
  logic [59:0] r_data;
  logic        r_start;
  logic        r_ntt_done;
  logic        w_xfer;
  logic [10:0] w_map;
  // The core field must fit inside the 10 non-bank address bits.
  if (LOG_CORE_COUNT > 10) begin : g_bad_core_count
    $error("LOG_CORE_COUNT exceeds address width");
  end
`ifdef NTT_LOADER_BITREV_EN
  for (genvar i = 0; i < 11; i++) begin : g_rev
    assign w_map[i] = r_cnt[10-i];
  end
`else
  assign w_map = r_cnt;
`endif
  assign s_ready      = r_state == LOAD;
  assign w_xfer       = s_valid & s_ready;
  assign busy         = r_state != IDLE;
  assign write_enable = r_we;
  assign address_in   = r_addr;
  assign data_in      = r_data;
  assign start        = r_start;
  assign ntt_done     = r_ntt_done;
  // r_hold counts the two GAP cycles, then the two WAIT cycles that mask a stale done.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_hold     <= '0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
      r_start    <= 1'b0;
      r_ntt_done <= 1'b0;
    end else begin
      r_we       <= w_xfer;
      r_start    <= 1'b0;
      r_ntt_done <= 1'b0;
      if (w_xfer) begin
        r_addr <= w_map;
        r_data <= s_data;
        r_cnt  <= r_cnt + 11'd1;
      end
      case (r_state)
        IDLE: if (go) begin
          r_state <= LOAD;
          r_cnt   <= '0;
        end
        LOAD: if (w_xfer && &r_cnt) begin
          r_state <= GAP;
          r_hold  <= '0;
        end
        GAP: begin
          r_hold <= r_hold + 2'd1;
          if (r_hold == 2'd1) r_state <= START;
        end
        START: begin
          r_state <= WAIT;
          r_start <= 1'b1;
          r_hold  <= '0;
        end
        WAIT: if (r_hold != 2'd2) r_hold <= r_hold + 2'd1;
        else if (done) begin
          r_state    <= FIN;
          r_ntt_done <= 1'b1;
        end
        FIN: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ntt_loader.sv
// tb_ntt_loader: randomized runs of ntt_loader checked against a cycle-level reference model.
module tb_ntt_loader;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        go = 1'b0;
  logic [59:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        done = 1'b0;
  logic        s_ready, write_enable, start, busy, ntt_done;
  logic [10:0] address_in;
  logic [59:0] data_in;
  int          n_checks = 0;
  int          n_errors = 0;

  ntt_loader dut (
    .clk(clk), .rst_n(rst_n), .go(go), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .write_enable(write_enable), .address_in(address_in),
    .data_in(data_in), .start(start), .done(done), .busy(busy), .ntt_done(ntt_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Load address of the i-th word of a run.
  function automatic logic [10:0] map(input int i);
    logic [10:0] a, r;
    a = i[10:0];
    r = a;
`ifdef NTT_LOADER_BITREV_EN
    for (int b = 0; b < 11; b++) r[b] = a[10-b];
`endif
    return r;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; go = 1'b1; s_valid = 1'b1; done = 1'b0;
    @(posedge clk) #1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("rst_we", write_enable, 0);
      chk("rst_addr", address_in, 0);
      chk("rst_data", data_in, 0);
      chk("rst_start", start, 0);
      chk("rst_ready", s_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ntt_done", ntt_done, 0);
      @(posedge clk) #1;
    end
    rst_n = 1'b1; go = 1'b0; s_valid = 1'b0;
    @(posedge clk) #1;
  endtask

  // pct < 0 toggles s_valid each cycle; abort_at > 0 resets after that many words.
  task automatic run(input int pct, input bit idx_data, input int abort_at);
    int acc = 0, nwe = 0, t = -1, cyc = 0;
    bit loading = 1'b1, exp_we = 1'b0, tog = 1'b1, acc_now;
    logic [10:0] exp_a = '0;
    logic [59:0] exp_d = '0;
    go = 1'b1; s_valid = 1'b0;
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_ready", s_ready, 0);
    @(posedge clk) #1;
    while (t <= 110) begin
      s_valid = loading && (pct < 0 ? tog : ($urandom_range(99) < pct));
      tog = ~tog;
      s_data = idx_data ? 60'(acc) : {$urandom, $urandom};
      go = (t < 100) ? 1'($urandom) : 1'b0;
      done = (t < 0) ? 1'($urandom) : (t <= 4 || t >= 105);
      @(negedge clk);
      chk("ready", s_ready, loading);
      chk("we", write_enable, exp_we);
      if (write_enable) nwe++;
      if (exp_we) begin
        chk("addr", address_in, exp_a);
        chk("data", data_in, exp_d);
      end
      chk("busy", busy, t <= 106);
      chk("start", start, t == 3);
      chk("ntt_done", ntt_done, t == 106);
      acc_now = loading && s_valid;
      exp_we = acc_now;
      if (acc_now) begin
        exp_a = map(acc);
        exp_d = s_data;
        acc++;
        if (acc == 2048) loading = 1'b0;
      end
      if (t >= 0) t++;
      else if (acc_now && acc == 2048) t = 0;
      @(posedge clk) #1;
      if (acc_now && acc == abort_at) return;
      cyc++;
      if (cyc > 20000) begin
        chk("timeout", cyc, 0);
        return;
      end
    end
    done = 1'b0; go = 1'b0; s_valid = 1'b0;
    chk("nwrites", nwe, 2048);
  endtask

  initial begin
    do_reset();
    run(100, 1'b1, 0);
    run(-1, 1'b1, 0);
    run(60, 1'b0, 0);
    run(100, 1'b1, 1000);
    do_reset();
    run(100, 1'b1, 0);
    run(30, 1'b0, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
